sha256_msg_pad: RTL and testbench
=================================

// Module: sha256_msg_pad
// PURPOSE
//  Producer side of the SHA-256 message-schedule input: accepts a message as a 32-bit big-endian word stream,
//  appends the 0x80 byte, zero fill and 64-bit bit length, and presents complete 16x32 blocks
//  (m_i format, word 0 = first) with a valid/ready handshake to the schedule/compression path.
//  Handles multi-block messages and the extra block needed when padding overflows word 13.
// PARAMETERS
//  N      32  word width (SHA-256 fixed; other values unsupported)
//  M      16  words per block
//  LEN_W  64  bit-length field width, stored in words M-2 (high) and M-1 (low)
// PORTS
//  clk_i        in   1       clock, all logic on rising edge
//  rst_i        in   1       synchronous reset, active-low
//  in_valid_i   in   1       input word valid
//  in_ready_o   out  1       input word accepted when in_valid_i & in_ready_o
//  in_data_i    in   N       message word, byte 0 in [31:24]
//  in_last_i    in   1       word is the last of the message
//  in_nbytes_i  in   3       valid bytes in last word (1..4, MSB-aligned); ignored unless in_last_i
//  blk_o        out  N x M   unpacked block [0:M-1], stable while blk_valid_o
//  blk_valid_o  out  1       block available
//  blk_ready_i  in   1       consumer takes block when blk_valid_o & blk_ready_i
//  blk_first_o  out  1       qualifies blk_o: first block of a message (reload H0..H7)
//  blk_final_o  out  1       qualifies blk_o: last block of a message (digest ready after it)
// BEHAVIOUR
//  Reset (rst_i=0 at edge): state LOAD, idx=0, bitlen=0, first_flag=1, all outputs 0, blk_o all 0; overrides any activity.
//  FSM: LOAD -> (last word accepted) PAD -> LEN -> EMIT; LOAD -> (word 15 accepted, not last) EMIT; also PAD -> EMIT (overflow).
//  LOAD: in_ready_o=1; each accepted word -> blk[idx], idx++, bitlen += 32 (or 8*in_nbytes_i on last).
//   Last word, nbytes<4: unused bytes zeroed, 0x80 in first unused byte; pad_done=1. nbytes=4: pad_done=0.
//   Non-last word at idx 15 -> EMIT (blk_final_o=0).
//  PAD: in_ready_o=0; one word per cycle at idx: 0x80000000 if !pad_done (then pad_done=1), else 0; idx++.
//   Leaves when idx reaches 14 with pad_done -> LEN. If write lands at idx 15 with pad_done -> EMIT
//   (overflow block, final=0) and next block resumes PAD at idx 0 with pad_done=1.
//   Last word accepted at idx 15: nbytes<4 -> EMIT overflow (pad_done=1); nbytes=4 -> EMIT, next block writes 0x80000000 at idx 0.
//  LEN: one cycle, blk[14]=bitlen[63:32], blk[15]=bitlen[31:0]; -> EMIT with blk_final_o=1.
//  EMIT: blk_valid_o=1 from the cycle after entry until handshake; blk_o/first/final held; in_ready_o=0.
//   On handshake: blk_valid_o=0 next cycle, idx=0, first_flag=final; return to LOAD, or PAD if message still padding.
//   After final block, bitlen cleared to 0.
//  blk_first_o = first_flag latched at block start; single-block message shows first=final=1.
//  bitlen wraps modulo 2^64 (no error). blk_ready_i high before blk_valid_o has no effect.
//  Throughput: 1 word/cycle in LOAD; fill latency = (words to pad) + 1 LEN cycle; 1 bubble per handshake.
// CONFIGURATION
//  SHA_PAD_BYPASS_EN defined: extra port bypass_i (in, 1), sampled with the first accepted word of a message;
//   when 1, message is already padded: words loaded raw, no 0x80/length insertion, in_nbytes_i ignored,
//   block emitted on every 16th word, final=in_last_i on word 15; in_last_i elsewhere is a protocol error (ignored).
//  Not defined: no bypass_i port; padding always applied.
// STRUCTURE
//  Package sha256_pkg: word_t (logic[31:0]), block_t (word_t [0:15]), PAD_WORD=32'h8000_0000,
//   LEN_HI_IDX=14, LEN_LO_IDX=15, state enum pad_state_e {LOAD,PAD,LEN,EMIT}.
//  One sub-module: sha256_bitlen_cnt (64-bit counter: clear, add 8..32, sync active-low rst_i).
// TESTING
//  "abc": one word 0x61626300 nbytes=3 last -> one block, w0=0x61626380, w1..w14=0, w15=0x00000018, first=final=1.
//  Empty-pad word: 14 full words (56 bytes), last nbytes=4 -> block 1 w14=0x80000000 w15=0, final=0;
//   block 2 w0..13=0, w14=0, w15=0x000001C0, first=0, final=1.
//  16 full words (64 bytes) last -> block 1 raw, final=0; block 2 w0=0x80000000, w15=0x00000200, final=1.
//  Backpressure: hold blk_ready_i=0 for 10 cycles -> blk_o/flags stable, in_ready_o=0, in_valid_i ignored; release -> one handshake.
//  Reset mid-PAD (rst_i=0 one cycle) -> all outputs 0, next "abc" produces the exact block from test 1.
//  SHA_PAD_BYPASS_EN: bypass_i=1, 16 words 0..15 last on 15 -> blk_o==input words, first=final=1, no padding.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  localparam int N     = 32;
  localparam int M     = 16;
  localparam int LEN_W = 64;

  typedef logic [31:0] word_t;
  typedef word_t block_t [0:15];

  localparam word_t      PAD_WORD   = 32'h8000_0000;
  localparam logic [3:0] LEN_HI_IDX = 4'd14;
  localparam logic [3:0] LEN_LO_IDX = 4'd15;

  typedef enum logic [1:0] {LOAD, PAD, LEN, EMIT} pad_state_e;

  // Keep the valid leading bytes, drop the trailing ones and put the 0x80 marker right after them.
  function automatic word_t pad_last_word(input word_t w, input logic [2:0] nbytes);
    word_t r;
    case (nbytes)
      3'd1:    r = {w[31:24], 8'h80, 16'h0000};
      3'd2:    r = {w[31:16], 8'h80, 8'h00};
      3'd3:    r = {w[31:8], 8'h80};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha256_bitlen_cnt.sv
// 64-bit message bit-length accumulator; wraps modulo 2^64.
module sha256_bitlen_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        add_en_i,
  input  logic [5:0]  add_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_r;

  // Clear wins over add so a finished message never leaks into the next one.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r <= 64'h0;
    end else if (clr_i) begin
      cnt_r <= 64'h0;
    end else if (add_en_i) begin
      cnt_r <= cnt_r + {58'h0, add_i};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/sha256_msg_pad.sv
// Pads a 32-bit big-endian word stream into 16-word SHA-256 blocks with valid/ready output.
// Defining SHA_PAD_BYPASS_EN adds bypass_i for messages that arrive already padded.
module sha256_msg_pad
  import sha256_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  word_t      in_data_i,
  input  logic       in_last_i,
  input  logic [2:0] in_nbytes_i,
  output block_t     blk_o,
  output logic       blk_valid_o,
  input  logic       blk_ready_i,
  output logic       blk_first_o,
  output logic       blk_final_o
`ifdef SHA_PAD_BYPASS_EN
  ,
  input  logic       bypass_i
`endif
);

  pad_state_e  state_r, state_n;
  logic [3:0]  idx_r, idx_n;
  logic        pad_done_r, pad_done_n;
  logic        first_flag_r, first_flag_n;
  logic        resume_pad_r, resume_pad_n;
  logic        in_ready_r, in_ready_n;
  logic        blk_valid_r, blk_valid_n;
  logic        blk_first_r, blk_first_n;
  logic        blk_final_r, blk_final_n;
  block_t      blk_r, blk_n;

  logic        accept_s, full_last_s, first_word_s, byp_s;
  logic        cnt_clr_s, cnt_add_s;
  logic [5:0]  cnt_amt_s;
  logic [63:0] bitlen_s;

  assign accept_s     = in_valid_i & in_ready_r & (state_r == LOAD);
  // nbytes of 0 or above 4 is treated as a full word
  assign full_last_s  = (in_nbytes_i == 3'd0) || (in_nbytes_i >= 3'd4);
  assign first_word_s = first_flag_r && (idx_r == 4'd0);

`ifdef SHA_PAD_BYPASS_EN
  logic bypass_r;

  // Bypass mode is fixed for the whole message by its first accepted word.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bypass_r <= 1'b0;
    end else if (accept_s && first_word_s) begin
      bypass_r <= bypass_i;
    end else begin
      bypass_r <= bypass_r;
    end
  end

  assign byp_s = first_word_s ? bypass_i : bypass_r;
`else
  assign byp_s = 1'b0;
`endif

  sha256_bitlen_cnt u_bitlen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr_s),
    .add_en_i (cnt_add_s),
    .add_i    (cnt_amt_s),
    .cnt_o    (bitlen_s)
  );

  // Next-state, block fill and handshake logic.
  always_comb begin
    state_n      = state_r;
    idx_n        = idx_r;
    pad_done_n   = pad_done_r;
    first_flag_n = first_flag_r;
    resume_pad_n = resume_pad_r;
    blk_valid_n  = blk_valid_r;
    blk_first_n  = blk_first_r;
    blk_final_n  = blk_final_r;
    blk_n        = blk_r;
    cnt_clr_s    = 1'b0;
    cnt_add_s    = 1'b0;
    cnt_amt_s    = 6'd32;
    case (state_r)
      LOAD: begin
        if (accept_s && byp_s) begin
          blk_n[idx_r] = in_data_i;
          if (idx_r == 4'd15) begin
            state_n      = EMIT;
            blk_first_n  = first_flag_r;
            blk_final_n  = in_last_i;
            resume_pad_n = 1'b0;
          end else begin
            idx_n = idx_r + 4'd1;
          end
        end else if (accept_s) begin
          cnt_add_s = 1'b1;
          if (in_last_i) begin
            cnt_amt_s    = full_last_s ? 6'd32 : {in_nbytes_i, 3'b000};
            blk_n[idx_r] = full_last_s ? in_data_i : pad_last_word(in_data_i, in_nbytes_i);
            pad_done_n   = ~full_last_s;
            resume_pad_n = 1'b1;
            if (idx_r == 4'd15) begin
              state_n     = EMIT;
              blk_first_n = first_flag_r;
              blk_final_n = 1'b0;
            end else begin
              state_n = PAD;
              idx_n   = idx_r + 4'd1;
            end
          end else begin
            blk_n[idx_r] = in_data_i;
            resume_pad_n = 1'b0;
            if (idx_r == 4'd15) begin
              state_n     = EMIT;
              blk_first_n = first_flag_r;
              blk_final_n = 1'b0;
            end else begin
              idx_n = idx_r + 4'd1;
            end
          end
        end else begin
          state_n = LOAD;
        end
      end
      PAD: begin
        if (pad_done_r && (idx_r == LEN_HI_IDX)) begin
          state_n = LEN;
        end else begin
          blk_n[idx_r] = pad_done_r ? 32'h0000_0000 : PAD_WORD;
          pad_done_n   = 1'b1;
          // Marker or zeros spilled into word 15: no room for the length in this block
          if (idx_r == LEN_LO_IDX) begin
            state_n      = EMIT;
            blk_first_n  = first_flag_r;
            blk_final_n  = 1'b0;
            resume_pad_n = 1'b1;
          end else begin
            idx_n = idx_r + 4'd1;
          end
        end
      end
      LEN: begin
        blk_n[LEN_HI_IDX] = bitlen_s[63:32];
        blk_n[LEN_LO_IDX] = bitlen_s[31:0];
        state_n           = EMIT;
        blk_first_n       = first_flag_r;
        blk_final_n       = 1'b1;
        resume_pad_n      = 1'b0;
      end
      EMIT: begin
        if (!blk_valid_r) begin
          blk_valid_n = 1'b1;
        end else if (blk_ready_i) begin
          blk_valid_n  = 1'b0;
          blk_first_n  = 1'b0;
          blk_final_n  = 1'b0;
          idx_n        = 4'd0;
          first_flag_n = blk_final_r;
          cnt_clr_s    = blk_final_r;
          state_n      = resume_pad_r ? PAD : LOAD;
        end else begin
          blk_valid_n = 1'b1;
        end
      end
      default: begin
        state_n = LOAD;
      end
    endcase
    in_ready_n = (state_n == LOAD);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r      <= LOAD;
      idx_r        <= 4'd0;
      pad_done_r   <= 1'b0;
      first_flag_r <= 1'b1;
      resume_pad_r <= 1'b0;
      in_ready_r   <= 1'b0;
      blk_valid_r  <= 1'b0;
      blk_first_r  <= 1'b0;
      blk_final_r  <= 1'b0;
      blk_r        <= '{default: 32'h0000_0000};
    end else begin
      state_r      <= state_n;
      idx_r        <= idx_n;
      pad_done_r   <= pad_done_n;
      first_flag_r <= first_flag_n;
      resume_pad_r <= resume_pad_n;
      in_ready_r   <= in_ready_n;
      blk_valid_r  <= blk_valid_n;
      blk_first_r  <= blk_first_n;
      blk_final_r  <= blk_final_n;
      blk_r        <= blk_n;
    end
  end

  assign in_ready_o  = in_ready_r;
  assign blk_valid_o = blk_valid_r;
  assign blk_first_o = blk_first_r;
  assign blk_final_o = blk_final_r;
  assign blk_o       = blk_r;

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Scoreboard bench for sha256_msg_pad: byte-level padding model feeds an expected-block queue.
module tb_sha256_msg_pad;
  import sha256_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       in_valid_i;
  logic       in_ready_o;
  word_t      in_data_i;
  logic       in_last_i;
  logic [2:0] in_nbytes_i;
  block_t     blk_o;
  logic       blk_valid_o;
  logic       blk_ready_i;
  logic       blk_first_o;
  logic       blk_final_o;
`ifdef SHA_PAD_BYPASS_EN
  logic       bypass_i;
`endif

  sha256_msg_pad dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_nbytes_i (in_nbytes_i),
    .blk_o       (blk_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_first_o (blk_first_o),
    .blk_final_o (blk_final_o)
`ifdef SHA_PAD_BYPASS_EN
    ,
    .bypass_i    (bypass_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [511:0] d;
    logic         fst;
    logic         fin;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         ready_mode = 0;

  function automatic logic [511:0] pack_blk(input block_t b);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = b[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: standard SHA-256 byte padding, then cut into 64-byte blocks.
  task automatic model_push();
    logic [7:0]  p[$];
    logic [63:0] bl;
    exp_t        e;
    int          nblk;
    p  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) e.d[511-8*i -: 8] = p[64*b+i];
      e.fst = (b == 0);
      e.fin = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input word_t w, input logic last, input logic [2:0] nb);
    int n;
    n = 0;
    in_valid_i  = 1'b1;
    in_data_i   = w;
    in_last_i   = last;
    in_nbytes_i = nb;
    do begin
      @(negedge clk_i);
      n++;
    end while (!in_ready_o && n < 300);
    if (!in_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 300 cycles");
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic send_msg();
    int         len, nw;
    word_t      w;
    logic [2:0] nb;
    len = msg_q.size();
    nw  = (len + 3) / 4;
    model_push();
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++)
        w[31-8*j -: 8] = (4*k + j < len) ? msg_q[4*k+j] : 8'($urandom);
      nb = (k == nw - 1) ? 3'(len - 4*k) : 3'($urandom);
      send_word(w, k == nw - 1, nb);
    end
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 512'({in_ready_o, blk_valid_o, blk_first_o, blk_final_o}), 512'(0));
    check({name, "_blk"}, pack_blk(blk_o), 512'(0));
  endtask

  // Monitor: drives blk_ready_i and scores every handshake against the queue.
  initial begin
    exp_t e;
    blk_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      case (ready_mode)
        0:       blk_ready_i = ($urandom_range(0, 3) != 0);
        1:       blk_ready_i = 1'b0;
        default: blk_ready_i = 1'b1;
      endcase
      if (rst_i && blk_valid_o && blk_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_block: got block %0h expected none", pack_blk(blk_o));
        end else begin
          e = exp_q.pop_front();
          check("blk_data", pack_blk(blk_o), e.d);
          check("blk_flags", 512'({blk_first_o, blk_final_o}), 512'({e.fst, e.fin}));
        end
      end
    end
  end

  initial begin
    exp_t e;
    int   n;
    int   lens[13] = '{52, 53, 54, 55, 57, 60, 61, 62, 63, 65, 119, 120, 128};
    rst_i       = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = 32'h0;
    in_last_i   = 1'b0;
    in_nbytes_i = 3'd0;
`ifdef SHA_PAD_BYPASS_EN
    bypass_i    = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check_zero("reset");
    rst_i = 1'b1;

    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    rand_msg(56);
    send_msg();
    rand_msg(64);
    send_msg();
    foreach (lens[i]) begin
      rand_msg(lens[i]);
      send_msg();
    end
    for (int r = 0; r < 25; r++) begin
      rand_msg($urandom_range(1, 200));
      send_msg();
    end
    wait_drain(3000);

    // Backpressure: block must hold and input must stall for 10 cycles.
    ready_mode = 1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    n = 0;
    while (!blk_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    e = exp_q[0];
    in_valid_i  = 1'b1;
    in_data_i   = $urandom;
    in_last_i   = 1'b1;
    in_nbytes_i = 3'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      check("bp_blk", pack_blk(blk_o), e.d);
      check("bp_ctrl", 512'({blk_valid_o, in_ready_o, blk_first_o, blk_final_o}),
            512'({1'b1, 1'b0, e.fst, e.fin}));
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    ready_mode = 2;
    wait_drain(50);
    ready_mode = 0;

    // Reset while padding: partial block discarded, next message unaffected.
    msg_q = '{8'h11, 8'h22};
    send_msg();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_zero("midpad_reset");
    rst_i = 1'b1;
    exp_q.delete();
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    wait_drain(200);

`ifdef SHA_PAD_BYPASS_EN
    for (int i = 0; i < 16; i++) e.d[511-32*i -: 32] = 32'(i);
    e.fst = 1'b1;
    e.fin = 1'b1;
    exp_q.push_back(e);
    bypass_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_word(32'(i), i == 15, 3'd4);
      bypass_i = 1'b0;
    end
    wait_drain(200);
`endif

    repeat (5) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
